// File: rtl/fixed_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : fixed_seq_multiplier
//  Purpose  : Sequential signed Q16.16 multiplier. Operand magnitudes are
//             multiplied by a 32-step radix-2 shift-add into a 64-bit
//             accumulator. The Q16.16 result magnitude is truncated toward
//             zero, the sign is applied, and out-of-range results saturate
//             with an overflow flag.
//  Ports    : clk       - system clock, rising-edge active
//             rst       - synchronous active-high reset
//             start     - operation request, honoured only when idle
//             a, b      - Q16.16 signed operands, latched on acceptance
//             busy      - operation in flight
//             done      - one-cycle completion pulse
//             product   - Q16.16 signed result, held until the next done
//             overflow  - result was saturated, held with product
//  Revision : 1.0 - initial release
// ============================================================================
module fixed_seq_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic        overflow
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [4:0]  C_LAST_ITER = 5'd31;
    localparam logic [47:0] C_POS_LIMIT = 48'h0000_7FFF_FFFF;
    localparam logic [47:0] C_NEG_LIMIT = 48'h0000_8000_0000;
    localparam logic [31:0] C_POS_SAT   = 32'h7FFF_FFFF;
    localparam logic [31:0] C_NEG_SAT   = 32'h8000_0000;

    // ------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------
    logic [1:0]  state_q,    state_d;
    logic [63:0] mcand_q,    mcand_d;     // shifted multiplicand magnitude
    logic [31:0] mplier_q,   mplier_d;    // multiplier magnitude, LSB first
    logic [63:0] acc_q,      acc_d;       // full unsigned product magnitude
    logic [4:0]  cnt_q,      cnt_d;
    logic        sign_q,     sign_d;
    logic        done_q,     done_d;
    logic [31:0] product_q,  product_d;
    logic        overflow_q, overflow_d;

    // ------------------------------------------------------------------
    // FSM control strobes (driven by the output process)
    // ------------------------------------------------------------------
    logic w_load;     // accept a new operation
    logic w_step;     // perform one shift-add iteration
    logic w_commit;   // register the final result

    // ------------------------------------------------------------------
    // Operand magnitudes. The most negative value maps to 0x80000000,
    // which is its exact magnitude when read as unsigned.
    // ------------------------------------------------------------------
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;

    assign w_abs_a = a[31] ? (~a + 32'd1) : a;
    assign w_abs_b = b[31] ? (~b + 32'd1) : b;

    // ------------------------------------------------------------------
    // Result formatting. Dropping the 16 fraction bits of the magnitude
    // truncates toward zero before the sign is applied.
    // ------------------------------------------------------------------
    logic [47:0] w_mag;
    logic [31:0] w_res;
    logic        w_ovf;
    logic        w_unused_frac;

    assign w_mag         = acc_q[63:16];
    assign w_unused_frac = ^acc_q[15:0];

    always_comb begin
        w_res = 32'd0;
        w_ovf = 1'b0;
        if (!sign_q) begin
            if (w_mag > C_POS_LIMIT) begin
                w_res = C_POS_SAT;
                w_ovf = 1'b1;
            end else begin
                w_res = w_mag[31:0];
            end
        end else begin
            // A magnitude of exactly 2^31 is representable as a negative
            // value; two's complement of 0x80000000 is itself.
            if (w_mag > C_NEG_LIMIT) begin
                w_res = C_NEG_SAT;
                w_ovf = 1'b1;
            end else begin
                w_res = ~w_mag[31:0] + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == C_LAST_ITER) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs and datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        busy     = 1'b0;
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_commit = 1'b0;
        case (state_q)
            S_IDLE: begin
                w_load = start;
            end
            S_RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
            end
            S_FINISH: begin
                busy     = 1'b1;
                w_commit = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        product_d  = product_q;
        overflow_d = overflow_q;
        done_d     = w_commit;

        if (w_load) begin
            mcand_d  = {32'd0, w_abs_a};
            mplier_d = w_abs_b;
            sign_d   = a[31] ^ b[31];
            acc_d    = 64'd0;
            cnt_d    = 5'd0;
        end else if (w_step) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
        end

        if (w_commit) begin
            product_d  = w_res;
            overflow_d = w_ovf;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q    <= 64'd0;
            mplier_q   <= 32'd0;
            acc_q      <= 64'd0;
            cnt_q      <= 5'd0;
            sign_q     <= 1'b0;
            done_q     <= 1'b0;
            product_q  <= 32'd0;
            overflow_q <= 1'b0;
        end else begin
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            done_q     <= done_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
        end
    end

    assign done     = done_q;
    assign product  = product_q;
    assign overflow = overflow_q;

endmodule
`default_nettype wire
